// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encoding, data width and default bit period.
// Imported by the transmitter, the baud counter and the receiver.
package uart_tx_pkg;

   typedef enum logic [1:0] {
      UART_IDLE  = 2'd0,
      UART_START = 2'd1,
      UART_DATA  = 2'd2,
      UART_STOP  = 2'd3
   } uart_state_t;

   localparam int UART_DATA_BITS    = 8;
   localparam int UART_CLKS_PER_BIT = 5208;

endpackage

// File: rtl/uart_tx_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, pulses o_tick on the last count and wraps.
// i_restart holds the count at zero so a frame always starts with a full bit period.
module uart_baud_tick
   import uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_restart,
   output logic o_tick
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] r_cnt;

   assign o_tick = (r_cnt == LAST);

   always_ff @(posedge i_clk) begin
      if (i_rst || i_restart || o_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register so the next byte can queue mid-frame.
// Frame: start bit, 8 data bits LSB first, STOP_BITS stop bits; tx comes straight from a flop.
module uart_tx
   import uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int STOP_BITS    = 1
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx,
   output logic       tx_busy
);

   if (CLKS_PER_BIT < 2 || !(STOP_BITS == 1 || STOP_BITS == 2)) begin : g_param_check
      $error("uart_tx: CLKS_PER_BIT must be >= 2 and STOP_BITS must be 1 or 2");
   end

   localparam logic [2:0] LAST_BIT  = 3'(UART_DATA_BITS - 1);
   localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

   uart_state_t               r_state, w_state_nxt;
   logic [UART_DATA_BITS-1:0] r_hold, r_shift, w_shift_nxt;
   logic                      r_hold_full, w_hold_full_nxt;
   logic [2:0]                r_bit_idx, w_bit_idx_nxt;
   logic                      r_stop_cnt, w_stop_cnt_nxt;
   logic                      r_tx, w_tx_nxt;
   logic                      r_tx_ready, r_tx_busy;
   logic                      w_tick, w_accept, w_load, w_baud_restart;

   assign w_accept       = tx_valid & r_tx_ready;
   assign w_baud_restart = (r_state == UART_IDLE);

   uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .i_clk     (CLOCK_50),
      .i_rst     (reset),
      .i_restart (w_baud_restart),
      .o_tick    (w_tick)
   );

   always_comb begin
      w_state_nxt    = r_state;
      w_shift_nxt    = r_shift;
      w_bit_idx_nxt  = r_bit_idx;
      w_stop_cnt_nxt = r_stop_cnt;
      w_load         = 1'b0;
      w_tx_nxt       = 1'b1;
      case (r_state)
         UART_IDLE: begin
            if (r_hold_full) begin
               w_load      = 1'b1;
               w_state_nxt = UART_START;
            end
         end
         UART_START: begin
            if (w_tick) begin
               w_state_nxt   = UART_DATA;
               w_bit_idx_nxt = '0;
            end
         end
         UART_DATA: begin
            if (w_tick) begin
               if (r_bit_idx == LAST_BIT) begin
                  w_state_nxt    = UART_STOP;
                  w_stop_cnt_nxt = 1'b0;
               end else begin
                  w_bit_idx_nxt = r_bit_idx + 3'd1;
                  w_shift_nxt   = r_shift >> 1;
               end
            end
         end
         UART_STOP: begin
            if (w_tick) begin
               if (r_stop_cnt == LAST_STOP) begin
                  // A queued byte chains straight into the next start bit.
                  if (r_hold_full) begin
                     w_load      = 1'b1;
                     w_state_nxt = UART_START;
                  end else begin
                     w_state_nxt = UART_IDLE;
                  end
               end else begin
                  w_stop_cnt_nxt = 1'b1;
               end
            end
         end
         default: w_state_nxt = UART_IDLE;
      endcase

      if (w_load) begin
         w_shift_nxt = r_hold;
      end
      // Accept and load are mutually exclusive: accept needs an empty hold, load a full one.
      w_hold_full_nxt = w_accept | (r_hold_full & ~w_load);

      case (w_state_nxt)
         UART_START: w_tx_nxt = 1'b0;
         UART_DATA:  w_tx_nxt = w_shift_nxt[0];
         default:    w_tx_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_state     <= UART_IDLE;
         r_hold_full <= 1'b0;
         r_bit_idx   <= '0;
         r_stop_cnt  <= 1'b0;
         r_tx        <= 1'b1;
         r_tx_ready  <= 1'b1;
         r_tx_busy   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_hold_full <= w_hold_full_nxt;
         r_bit_idx   <= w_bit_idx_nxt;
         r_stop_cnt  <= w_stop_cnt_nxt;
         r_tx        <= w_tx_nxt;
         r_tx_ready  <= ~w_hold_full_nxt;
         r_tx_busy   <= (w_state_nxt != UART_IDLE) | w_hold_full_nxt;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      r_shift <= w_shift_nxt;
      if (w_accept) begin
         r_hold <= tx_data;
      end
   end

   assign tx       = r_tx;
   assign tx_ready = r_tx_ready;
   assign tx_busy  = r_tx_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame-level model checked every cycle, plus directed literal checks.
module tb_uart_tx;

   localparam int CPB   = 4;
   localparam int FRAME = 10 * CPB;
   localparam int CPB2  = 434;

   typedef struct {
      int         acc;
      int         start;
      logic [7:0] d;
   } frame_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, tx_valid, tx_ready, tx, tx_busy;
   logic [7:0] tx_data;
   logic       reset2, tx_valid2, tx_ready2, tx2, tx_busy2;
   logic [7:0] tx_data2;

   uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
      .CLOCK_50 (clk),
      .reset    (reset),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx       (tx),
      .tx_busy  (tx_busy)
   );

   uart_tx #(.CLKS_PER_BIT(CPB2), .STOP_BITS(2)) dut2 (
      .CLOCK_50 (clk),
      .reset    (reset2),
      .tx_data  (tx_data2),
      .tx_valid (tx_valid2),
      .tx_ready (tx_ready2),
      .tx       (tx2),
      .tx_busy  (tx_busy2)
   );

   int         checks = 0;
   int         errors = 0;
   int         cyc    = 0;
   bit         cmp_en = 1'b0;
   frame_t     fq[$];
   logic [7:0] rxq[$];

   // Model: each accepted byte owns a frame window [start, start+FRAME); it waits in the
   // hold from its accept edge until its start edge.
   function automatic bit hold_full_at(input int k);
      foreach (fq[i]) if (fq[i].acc <= k && k < fq[i].start) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic exp_tx(input int k);
      foreach (fq[i]) begin
         if (k >= fq[i].start && k < fq[i].start + FRAME) begin
            int pos;
            pos = (k - fq[i].start) / CPB;
            if (pos == 0) return 1'b0;
            if (pos <= 8) return fq[i].d[pos-1];
            return 1'b1;
         end
      end
      return 1'b1;
   endfunction

   function automatic logic exp_busy(input int k);
      if (hold_full_at(k)) return 1'b1;
      foreach (fq[i]) if (k >= fq[i].start && k < fq[i].start + FRAME) return 1'b1;
      return 1'b0;
   endfunction

   always @(posedge clk) begin : model
      int     st;
      frame_t f;
      cyc = cyc + 1;
      if (reset) begin
         fq.delete();
      end else if (tx_valid && !hold_full_at(cyc - 1)) begin
         st = cyc + 1;
         if (fq.size() > 0 && fq[$].start + FRAME > st) st = fq[$].start + FRAME;
         f.acc   = cyc;
         f.start = st;
         f.d     = tx_data;
         fq.push_back(f);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("cyc_tx", {31'd0, tx}, {31'd0, exp_tx(cyc)});
         chk("cyc_tx_ready", {31'd0, tx_ready}, {31'd0, ~hold_full_at(cyc)});
         chk("cyc_tx_busy", {31'd0, tx_busy}, {31'd0, exp_busy(cyc)});
      end
   end

   // Line-level receiver for the CPB=4 instance, sampling mid-bit.
   always begin : rx_model
      logic [7:0] b;
      @(negedge clk);
      if (cmp_en && tx === 1'b0) begin
         repeat (CPB / 2) @(negedge clk);
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = tx;
         end
         repeat (CPB) @(negedge clk);
         if (tx === 1'b1) rxq.push_back(b);
      end
   end

   task automatic wait_edge(input int k);
      int n;
      n = 0;
      while (cyc < k && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (cyc != k) chk("wait_edge", cyc, k);
   endtask

   // Called at a negedge; returns at the negedge just after the accept edge.
   task automatic send(input logic [7:0] b, output int acc);
      int n;
      n = 0;
      tx_valid = 1'b1;
      tx_data  = b;
      while (!tx_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!tx_ready) chk("send_timeout", 0, 1);
      acc = cyc + 1;
      @(negedge clk);
      tx_valid = 1'b0;
      tx_data  = 8'hC3;
   endtask

   initial begin
      int         a, b1, b2, c, d, n, got, lows, st;
      logic       rdy;
      logic [7:0] r6;
      logic [7:0] seq4 [3];
      int         a5_seq [8];

      reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
      reset2 = 1'b1; tx_valid2 = 1'b0; tx_data2 = 8'h00;

      // 1: reset for two edges, then idle line.
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0; reset2 = 1'b0; cmp_en = 1'b1;
      chk("rst_tx", {31'd0, tx}, 1);
      chk("rst_tx_ready", {31'd0, tx_ready}, 1);
      chk("rst_tx_busy", {31'd0, tx_busy}, 0);
      lows = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      chk("idle_20_no_low", lows, 0);

      // 2: single frame of 0xA5.
      a5_seq = '{1, 0, 1, 0, 0, 1, 0, 1};
      send(8'hA5, a);
      chk("a5_before_start", {31'd0, tx}, 1);
      chk("a5_busy_on_accept", {31'd0, tx_busy}, 1);
      wait_edge(a + 1);
      chk("a5_start_fall", {31'd0, tx}, 0);
      for (int i = 0; i < 8; i++) begin
         wait_edge(a + 1 + CPB * (i + 1) + 2);
         chk("a5_data_bit", {31'd0, tx}, a5_seq[i]);
      end
      wait_edge(a + 1 + 9 * CPB + 2);
      chk("a5_stop", {31'd0, tx}, 1);
      wait_edge(a + 40);
      chk("a5_busy_last", {31'd0, tx_busy}, 1);
      wait_edge(a + 41);
      chk("a5_busy_end", {31'd0, tx_busy}, 0);

      // 3: 0x00 then 0xFF queued during data bits; zero gap between frames.
      send(8'h00, b1);
      wait_edge(b1 + 11);
      send(8'hFF, b2);
      chk("b2b_ready_low", {31'd0, tx_ready}, 0);
      wait_edge(b1 + 40);
      chk("b2b_stop_high", {31'd0, tx}, 1);
      chk("b2b_ready_still_low", {31'd0, tx_ready}, 0);
      wait_edge(b1 + 41);
      chk("b2b_no_gap_start", {31'd0, tx}, 0);
      chk("b2b_ready_after_xfer", {31'd0, tx_ready}, 1);
      wait_edge(b1 + 81);
      chk("b2b_busy_end", {31'd0, tx_busy}, 0);
      chk("rx_count_1", rxq.size(), 3);
      if (rxq.size() == 3) begin
         chk("rx_byte_a5", {24'd0, rxq[0]}, 32'hA5);
         chk("rx_byte_00", {24'd0, rxq[1]}, 32'h00);
         chk("rx_byte_ff", {24'd0, rxq[2]}, 32'hFF);
      end

      // 4: tx_valid held high, data advanced only on handshakes.
      rxq.delete();
      seq4 = '{8'h11, 8'h22, 8'h33};
      got = 0; n = 0;
      tx_valid = 1'b1; tx_data = seq4[0];
      while (got < 3 && n < 1000) begin
         rdy = tx_ready;
         @(negedge clk);
         n++;
         if (rdy) begin
            got++;
            if (got < 3) tx_data = seq4[got];
         end
      end
      tx_valid = 1'b0;
      chk("hold_valid_accepts", got, 3);
      n = 0;
      while (tx_busy && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("hold_valid_drain", {31'd0, tx_busy}, 0);
      chk("rx_count_2", rxq.size(), 3);
      if (rxq.size() == 3) begin
         chk("rx_byte_11", {24'd0, rxq[0]}, 32'h11);
         chk("rx_byte_22", {24'd0, rxq[1]}, 32'h22);
         chk("rx_byte_33", {24'd0, rxq[2]}, 32'h33);
      end

      // 5: reset during data bit 3 of 0x0F, with 0x55 queued behind it.
      send(8'h0F, c);
      send(8'h55, d);
      wait_edge(c + 18);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midrst_tx", {31'd0, tx}, 1);
      chk("midrst_tx_ready", {31'd0, tx_ready}, 1);
      chk("midrst_tx_busy", {31'd0, tx_busy}, 0);
      lows = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      chk("midrst_no_low", lows, 0);
      rxq.delete();

      // 6: two stop bits at CPB=434, decoded by a bench receiver.
      chk("r6_ready", {31'd0, tx_ready2}, 1);
      tx_valid2 = 1'b1; tx_data2 = 8'h3C;
      @(negedge clk);
      tx_valid2 = 1'b0; tx_data2 = 8'h00;
      chk("r6_before_start", {31'd0, tx2}, 1);
      @(negedge clk);
      chk("r6_start_fall", {31'd0, tx2}, 0);
      repeat (CPB2 / 2) @(negedge clk);
      chk("r6_start_mid", {31'd0, tx2}, 0);
      for (int i = 0; i < 8; i++) begin
         repeat (CPB2) @(negedge clk);
         r6[i] = tx2;
      end
      chk("r6_rx_byte", {24'd0, r6}, 32'h3C);
      n = 0;
      while (tx2 !== 1'b1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      st = 0; lows = 0;
      while (tx_busy2 && st < 2000) begin
         if (tx2 !== 1'b1) lows++;
         st++;
         @(negedge clk);
      end
      chk("r6_stop_cycles", st, 868);
      chk("r6_stop_high", lows, 0);

      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
